fc_layer_seq: RTL
=================

// Module: fc_layer_seq
// PURPOSE
// - Time-multiplexed fully connected layer. Consumes one flattened input pixel per beat
//   over a valid/ready stream and multiply-accumulates it against all OUTPUT_CHANNELS
//   weights in parallel.
// - After FLAT_INPUT_SIZE beats, adds the biases, saturates, and presents one output
//   vector over a valid/ready stream.
// - Sits after the conv/pool stages. Replaces the fully unrolled combinational FC with
//   OUTPUT_CHANNELS MAC lanes.
// PARAMETERS
// - INPUT_SIZE       5   input width/height (square)
// - INPUT_CHANNELS   3   input features
// - OUTPUT_CHANNELS  3   output features = MAC lanes
// - PX_SIZE          8   bits per pixel/weight/bias, signed two's complement
// - ACC_SIZE         24  accumulator bits per lane, signed; must be >= 2*PX_SIZE+$clog2(FLAT_INPUT_SIZE)+1
// - FLAT_INPUT_SIZE  (localparam) INPUT_SIZE*INPUT_SIZE*INPUT_CHANNELS
// - IDX_W            (localparam) $clog2(FLAT_INPUT_SIZE)
// PORTS
// - clk        in   1                        single clock, rising edge
// - rst        in   1                        asynchronous, active-high reset
// - in_valid   in   1                        input pixel valid
// - in_ready   out  1                        block accepts pixel
// - in_data    in   PX_SIZE                  flattened pixel, order x,y,c (c fastest)
// - in_last    in   1                        producer marks final pixel of frame
// - w_addr     out  IDX_W                    index of pixel expected on this beat
// - w_data     in   OUTPUT_CHANNELS*PX_SIZE  weights for w_addr, lane o at [o*PX_SIZE+:PX_SIZE], combinational
// - biases     in   OUTPUT_CHANNELS*PX_SIZE  static per-lane bias
// - out_valid  out  1                        output vector valid
// - out_ready  in   1                        consumer accepts output
// - out_data   out  OUTPUT_CHANNELS*PX_SIZE  saturated results, lane o at [o*PX_SIZE+:PX_SIZE]
// - frame_err  out  1                        one-cycle pulse: in_last misplaced
// - busy       out  1                        high when count!=0 or state!=ACCUM
// BEHAVIOUR
// - Reset values:
//   - state=ACCUM, count=0, all acc=0.
//   - out_valid=0, out_data=0, frame_err=0, in_ready=1 once reset deasserts.
// - FSM:
//   - ACCUM: in_ready=1. Beat = in_valid&in_ready.
//     - Each beat: acc[o] += sext(in_data)*sext(w_data[o]) for every lane; count++.
//     - Beat with count==FLAT_INPUT_SIZE-1: goes to FINAL, count returns to 0.
//   - FINAL (1 cycle): in_ready=0.
//     - res[o] = acc[o] + sext(biases[o]), saturated to [-2^(PX_SIZE-1), 2^(PX_SIZE-1)-1].
//     - res registered into out_data; out_valid set; goes to OUTPUT.
//   - OUTPUT: in_ready=0; out_data and out_valid held stable.
//     - On out_valid&out_ready: out_valid=0, all acc=0, goes to ACCUM.
// - w_addr=count, combinational from the register. Weight memory is asynchronous-read.
// - Latency: last beat in cycle t, out_valid high in cycle t+2. Throughput is one
//   frame per FLAT_INPUT_SIZE+2 cycles with out_ready held high.
// - in_last checking:
//   - frame_err pulses the cycle after a beat where in_last != (count==FLAT_INPUT_SIZE-1).
//   - The frame length is always FLAT_INPUT_SIZE beats; in_last never truncates or extends a frame.
// - Arithmetic: full-precision products, signed ACC_SIZE accumulate. No accumulator
//   saturation; the ACC_SIZE rule guarantees no overflow.
// - in_valid is ignored outside ACCUM; no beat is lost or duplicated across state changes.
// - rst mid-frame: partial sums and count discarded immediately. The next beat is index 0.
// CONFIGURATION
// - Macro FC_RELU_EN.
// - Defined: FINAL applies ReLU before saturation; negative res gives out_data lane = 0.
// - Undefined: signed saturation only, negative results pass through.
// TESTING
// - Ones: 75 beats, in_data=1, all w=1, bias=0 -> out_valid at t+2, every lane=75, frame_err=0.
// - Positive saturation: in_data=10, w=10, bias=0 -> sum 7500 -> every lane=127.
// - Negative saturation: in_data=2, w=-1, bias=5 -> -145 -> lanes=-128.
//   With FC_RELU_EN, lanes=0.
// - Backpressure:
//   - out_ready=0 for 10 cycles -> out_data stable, in_ready=0, in_valid beats not counted.
//   - Then out_ready=1 for 1 cycle -> next frame of ones again gives 75.
// - Reset mid-frame: rst after 40 beats, then a full 75-beat ones frame -> lanes=75,
//   not 115; w_addr=0 after reset.
// - Framing: in_last on beat 40 and not on beat 75 -> frame_err pulses twice.
//   Output is still produced after beat 75 with the correct value.

Source files
------------

// File: rtl/fc_layer_seq.sv
// Sequential fully connected layer: one pixel per beat MAC'd into
// OUTPUT_CHANNELS lanes, then bias + saturate, one output vector per frame.
// Ports: clk, rst (async high); in_valid/in_ready/in_data/in_last pixel
// stream; w_addr/w_data async weight memory; biases; out_valid/out_ready/
// out_data result stream; frame_err misplaced in_last pulse; busy.
// Macro FC_RELU_EN: apply ReLU before saturation.
module fc_layer_seq #(
  parameter int INPUT_SIZE = 5,
  parameter int INPUT_CHANNELS = 3,
  parameter int OUTPUT_CHANNELS = 3,
  parameter int PX_SIZE = 8,
  parameter int ACC_SIZE = 24,
  localparam int FLAT_INPUT_SIZE =
    INPUT_SIZE * INPUT_SIZE * INPUT_CHANNELS,
  localparam int IDX_W = $clog2(FLAT_INPUT_SIZE)
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [PX_SIZE-1:0] in_data,
  input  logic in_last,
  output logic [IDX_W-1:0] w_addr,
  input  logic [OUTPUT_CHANNELS*PX_SIZE-1:0] w_data,
  input  logic [OUTPUT_CHANNELS*PX_SIZE-1:0] biases,
  output logic out_valid,
  input  logic out_ready,
  output logic [OUTPUT_CHANNELS*PX_SIZE-1:0] out_data,
  output logic frame_err,
  output logic busy
);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FINAL  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FLAT_INPUT_SIZE - 1);
  localparam logic signed [ACC_SIZE:0] SMAX =
    (ACC_SIZE+1)'(2**(PX_SIZE-1) - 1);
  localparam logic signed [ACC_SIZE:0] SMIN = ~SMAX;
  localparam logic [PX_SIZE-1:0] LMAX = {1'b0, {(PX_SIZE-1){1'b1}}};
  localparam logic [PX_SIZE-1:0] LMIN = {1'b1, {(PX_SIZE-1){1'b0}}};

  state_t state, state_n;
  logic [IDX_W-1:0] count;
  logic signed [ACC_SIZE-1:0] acc [OUTPUT_CHANNELS];
  logic signed [2*PX_SIZE-1:0] prod [OUTPUT_CHANNELS];
  logic [OUTPUT_CHANNELS*PX_SIZE-1:0] res;
  logic signed [ACC_SIZE:0] s;
  logic [PX_SIZE-1:0] b;
  logic beat;
  logic at_last;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUTPUT);
  assign beat      = in_valid & in_ready;
  assign at_last   = (count == LAST);
  assign w_addr    = count;
  assign busy      = (count != '0) || (state != ACCUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ACCUM:   if (beat && at_last) state_n = FINAL;
      FINAL:   state_n = OUTPUT;
      OUTPUT:  if (out_ready) state_n = ACCUM;
      default: state_n = ACCUM;
    endcase
  end

  always_comb begin
    for (int o = 0; o < OUTPUT_CHANNELS; o++)
      prod[o] = $signed(in_data) *
                $signed(w_data[o*PX_SIZE +: PX_SIZE]);
  end

  // Sum is one bit wider than acc so the bias add cannot wrap
  always_comb begin
    res = '0;
    s = '0;
    b = '0;
    for (int o = 0; o < OUTPUT_CHANNELS; o++) begin
      b = biases[o*PX_SIZE +: PX_SIZE];
      s = {acc[o][ACC_SIZE-1], acc[o]} +
          {{(ACC_SIZE+1-PX_SIZE){b[PX_SIZE-1]}}, b};
`ifdef FC_RELU_EN
      if (s < 0)
        res[o*PX_SIZE +: PX_SIZE] = '0;
      else if (s > SMAX)
        res[o*PX_SIZE +: PX_SIZE] = LMAX;
      else
        res[o*PX_SIZE +: PX_SIZE] = s[PX_SIZE-1:0];
`else
      if (s > SMAX)
        res[o*PX_SIZE +: PX_SIZE] = LMAX;
      else if (s < SMIN)
        res[o*PX_SIZE +: PX_SIZE] = LMIN;
      else
        res[o*PX_SIZE +: PX_SIZE] = s[PX_SIZE-1:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      out_data <= '0;
      frame_err <= 1'b0;
      for (int o = 0; o < OUTPUT_CHANNELS; o++)
        acc[o] <= '0;
    end else begin
      frame_err <= 1'b0;
      if (beat) begin
        for (int o = 0; o < OUTPUT_CHANNELS; o++)
          acc[o] <= acc[o] +
            {{(ACC_SIZE-2*PX_SIZE){prod[o][2*PX_SIZE-1]}}, prod[o]};
        count <= at_last ? '0 : count + 1'b1;
        frame_err <= (in_last != at_last);
      end
      if (state == FINAL)
        out_data <= res;
      if (state == OUTPUT && out_ready)
        for (int o = 0; o < OUTPUT_CHANNELS; o++)
          acc[o] <= '0;
    end
  end

endmodule
